// File: rtl/irq_pkg.sv
// Shared definitions for the 68000 interrupt controller: register map,
// FSM state encoding, CTRL nibble layout and the level priority encoder.
package irq_pkg;

    // Register offsets (cpu_addr[2:1])
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MASK    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Channel count is tied to the three autovectored levels
    localparam int unsigned CH_COUNT = 3;

    // CTRL layout: one nibble per channel, select in the low bits, invert on top
    localparam int unsigned CH_NIB_W = 4;
    localparam int unsigned INV_BIT  = 3;
    localparam logic [15:0] CTRL_RW_MASK = 16'h0FFF;

    // STATUS layout
    localparam int unsigned STATUS_SPUR_BIT = 2;
    localparam int unsigned STATUS_OVF_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        ACK
    } irq_state_t;

    // Highest requesting channel wins; channel i maps to level i+1
    function automatic logic [1:0] highest_level(input logic [CH_COUNT-1:0] req);
        highest_level = 2'd0;
        for (int unsigned i = 0; i < CH_COUNT; i++) begin
            if (req[i]) highest_level = 2'(i + 1);
        end
    endfunction

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: source select, polarity, rising-edge detect with
// suppression after CTRL writes, and the pending/overflow latches.
module irq_channel
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_sync,
    input  logic [SEL_W-1:0]   sel,
    input  logic               invert,
    input  logic               ctrl_wr,
    input  logic               pend_clr,
    input  logic               ovf_clr,
    output logic               pending,
    output logic               overflow
);

    logic chan_val;
    logic prev_q;
    logic suppress_q;
    logic edge_det;

    // Source mux plus polarity; select 0 or an out-of-range code is constant 0
    always_comb begin
        chan_val = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i + 1)) chan_val = src_sync[i] ^ invert;
        end
    end

    // The cycle after a CTRL write compares against a value produced by the
    // old select/polarity, so that comparison is skipped while prev reloads.
    assign edge_det = chan_val & ~prev_q & ~suppress_q;

    // Edge history, suppression flag and latched pending/overflow (set wins)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= 1'b0;
            suppress_q <= 1'b0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            prev_q     <= chan_val;
            suppress_q <= ctrl_wr;
            if (edge_det)      pending <= 1'b1;
            else if (pend_clr) pending <= 1'b0;
            if (edge_det && pending && !pend_clr) overflow <= 1'b1;
            else if (ovf_clr)                     overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable 68000 interrupt controller: maps raw sources onto levels 1..3,
// drives the fx68k IPL lines and answers IACK with an autovector request.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_CH  = CH_COUNT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [1:0]         wr,
    input  logic [1:0]         address,
    input  logic [15:0]        din,
    output logic [15:0]        dout,
    input  logic [2:0]         cpu_fc,
    input  logic               cpu_as_n,
    input  logic [2:0]         iack_level,
    output logic [2:0]         ipl_n,
    output logic               vpa_n,
    output logic               irq_active
);

    logic [NUM_SRC-1:0] src_meta;
    logic [NUM_SRC-1:0] src_sync;

    logic [15:0]       ctrl_q;
    logic [NUM_CH-1:0] mask_q;
    logic              spurious_q;
    logic [1:0]        lvl_q;
    irq_state_t        state;

    logic              is_wr;
    logic              ctrl_wr_en;
    logic [15:0]       ctrl_wmask;
    logic [NUM_CH-1:0] pend_w1c;
    logic [NUM_CH-1:0] ovf_clr;
    logic              spur_clr;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overflow;
    logic [1:0]        level;

    logic              iack;
    logic              iack_take;
    logic [NUM_CH-1:0] iack_clr;
    logic              spur_set;

    // Two-flop synchroniser for the asynchronous event sources
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_meta <= '0;
            src_sync <= '0;
        end else begin
            src_meta <= src_in;
            src_sync <= src_meta;
        end
    end

    // Bus write decode with byte-lane qualification
    always_comb begin
        is_wr      = |wr;
        ctrl_wr_en = is_wr && (address == REG_CTRL);
        ctrl_wmask = '0;
        if (ctrl_wr_en) ctrl_wmask = {{8{wr[1]}}, {8{wr[0]}}} & CTRL_RW_MASK;
        pend_w1c = '0;
        if (is_wr && (address == REG_PENDING) && wr[0]) pend_w1c = din[NUM_CH-1:0];
        ovf_clr = '0;
        if (is_wr && (address == REG_STATUS) && wr[1]) ovf_clr = din[STATUS_OVF_LSB +: NUM_CH];
        spur_clr = is_wr && (address == REG_STATUS) && wr[0] && din[STATUS_SPUR_BIT];
    end

    // One channel per interrupt level
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        irq_channel #(
            .NUM_SRC(NUM_SRC),
            .SEL_W  (SEL_W)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .src_sync(src_sync),
            .sel     (ctrl_q[c*CH_NIB_W +: SEL_W]),
            .invert  (ctrl_q[c*CH_NIB_W + INV_BIT]),
            .ctrl_wr (ctrl_wr_en & wr[(c*CH_NIB_W)/8]),
            .pend_clr(pend_w1c[c] | iack_clr[c]),
            .ovf_clr (ovf_clr[c]),
            .pending (pending[c]),
            .overflow(overflow[c])
        );
    end

    assign level = highest_level(pending & mask_q);

    // IACK acceptance: clear the acknowledged pending bit or flag spurious
    always_comb begin
        iack      = (cpu_fc == 3'b111) && !cpu_as_n;
        iack_take = iack && (state != ACK);
        iack_clr  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (iack_take && (state == ASSERT) && (iack_level == 3'(i + 1)) && pending[i])
                iack_clr[i] = 1'b1;
        end
        spur_set = iack_take && !(|iack_clr);
    end

    // Control, mask and spurious-flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            mask_q     <= '0;
            spurious_q <= 1'b0;
        end else begin
            ctrl_q <= (ctrl_q & ~ctrl_wmask) | (din & ctrl_wmask);
            if (is_wr && (address == REG_MASK) && wr[0]) mask_q <= din[NUM_CH-1:0];
            if (spur_set)      spurious_q <= 1'b1;
            else if (spur_clr) spurious_q <= 1'b0;
        end
    end

    // IPL / IACK handshake FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ipl_n <= 3'b111;
            vpa_n <= 1'b1;
            lvl_q <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (iack) begin
                        state <= ACK;
                        vpa_n <= 1'b0;
                    end else if (level != 2'd0) begin
                        state <= ASSERT;
                        ipl_n <= ~{1'b0, level};
                        lvl_q <= level;
                    end
                end
                ASSERT: begin
                    if (iack) begin
                        state <= ACK;
                        ipl_n <= 3'b111;
                        vpa_n <= 1'b0;
                        lvl_q <= 2'd0;
                    end else if (level == 2'd0) begin
                        state <= IDLE;
                        ipl_n <= 3'b111;
                        lvl_q <= 2'd0;
                    end else begin
                        ipl_n <= ~{1'b0, level};
                        lvl_q <= level;
                    end
                end
                ACK: begin
                    if (cpu_as_n) begin
                        state <= IDLE;
                        vpa_n <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ipl_n <= 3'b111;
                    vpa_n <= 1'b1;
                    lvl_q <= 2'd0;
                end
            endcase
        end
    end

    assign irq_active = (ipl_n != 3'b111);

    // Register read mux
    always_comb begin
        dout = '0;
        case (address)
            REG_CTRL:    dout = ctrl_q;
            REG_PENDING: dout = 16'(pending);
            REG_MASK:    dout = 16'(mask_q);
            REG_STATUS: begin
                dout[1:0]                            = lvl_q;
                dout[STATUS_SPUR_BIT]                = spurious_q;
                dout[STATUS_OVF_LSB +: NUM_CH]       = overflow;
            end
            default:     dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_MASK    = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  src_in;
    logic [1:0]  wr;
    logic [1:0]  address;
    logic [15:0] din;
    logic [15:0] dout;
    logic [2:0]  cpu_fc;
    logic        cpu_as_n;
    logic [2:0]  iack_level;
    logic [2:0]  ipl_n;
    logic        vpa_n;
    logic        irq_active;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    irq_ctrl #(
        .NUM_SRC(4),
        .SEL_W  (3),
        .NUM_CH (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .src_in    (src_in),
        .wr        (wr),
        .address   (address),
        .din       (din),
        .dout      (dout),
        .cpu_fc    (cpu_fc),
        .cpu_as_n  (cpu_as_n),
        .iack_level(iack_level),
        .ipl_n     (ipl_n),
        .vpa_n     (vpa_n),
        .irq_active(irq_active)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wreg(input logic [1:0] a, input logic [15:0] d, input logic [1:0] lanes);
        address = a;
        din     = d;
        wr      = lanes;
        tick(1);
        wr      = 2'b00;
        din     = '0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        address = a;
        #1;
        chk(tag, dout, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        src_in     = '0;
        wr         = 2'b00;
        address    = A_CTRL;
        din        = '0;
        cpu_fc     = 3'b000;
        cpu_as_n   = 1'b1;
        iack_level = 3'd0;

        // Reset state
        tick(2);
        chk("rst_ipl", 16'(ipl_n), 16'h0007);
        chk("rst_vpa", 16'(vpa_n), 16'h0001);
        chk("rst_active", 16'(irq_active), 16'h0000);
        chk_reg("rst_ctrl", A_CTRL, 16'h0000);
        chk_reg("rst_pend", A_PENDING, 16'h0000);
        chk_reg("rst_status", A_STATUS, 16'h0000);
        reset_n = 1'b1;
        tick(2);

        // Basic level-1 interrupt and IACK
        wreg(A_CTRL, 16'h0001, 2'b11);
        wreg(A_MASK, 16'h0001, 2'b01);
        chk_reg("t1_ctrl_rd", A_CTRL, 16'h0001);
        src_in = 4'b0001;
        tick(2);
        chk_reg("t1_pend_early", A_PENDING, 16'h0000);
        tick(1);
        chk_reg("t1_pend_set", A_PENDING, 16'h0001);
        chk("t1_ipl_not_yet", 16'(ipl_n), 16'h0007);
        tick(1);
        chk("t1_ipl", 16'(ipl_n), 16'h0006);
        chk("t1_active", 16'(irq_active), 16'h0001);
        chk_reg("t1_status_lvl", A_STATUS, 16'h0001);
        src_in = 4'b0000;
        cpu_fc = 3'b111; iack_level = 3'd1; cpu_as_n = 1'b0;
        tick(1);
        chk("t1_vpa_ack", 16'(vpa_n), 16'h0000);
        chk("t1_ipl_ack", 16'(ipl_n), 16'h0007);
        chk_reg("t1_pend_clr", A_PENDING, 16'h0000);
        chk_reg("t1_status_ack", A_STATUS, 16'h0000);
        tick(1);
        chk("t1_vpa_hold", 16'(vpa_n), 16'h0000);
        cpu_as_n = 1'b1;
        tick(1);
        chk("t1_vpa_rel", 16'(vpa_n), 16'h0001);
        cpu_fc = 3'b000;

        // Priority: ch0 + ch2 pending, then clear ch2
        wreg(A_CTRL, 16'h0301, 2'b11);
        wreg(A_MASK, 16'h0005, 2'b01);
        src_in = 4'b0101;
        tick(3);
        chk_reg("t2_pend", A_PENDING, 16'h0005);
        tick(1);
        chk("t2_ipl_l3", 16'(ipl_n), 16'h0004);
        chk_reg("t2_status_l3", A_STATUS, 16'h0003);
        src_in = 4'b0000;
        wreg(A_PENDING, 16'h0004, 2'b01);
        chk("t2_ipl_lag", 16'(ipl_n), 16'h0004);
        chk_reg("t2_pend_w1c", A_PENDING, 16'h0001);
        tick(1);
        chk("t2_ipl_l1", 16'(ipl_n), 16'h0006);
        chk_reg("t2_status_l1", A_STATUS, 16'h0001);
        wreg(A_PENDING, 16'h0001, 2'b01);
        tick(1);
        chk("t2_ipl_idle", 16'(ipl_n), 16'h0007);

        // Overflow on ch1 and byte-lane qualified W1C
        wreg(A_MASK, 16'h0000, 2'b01);
        wreg(A_CTRL, 16'h0020, 2'b11);
        src_in = 4'b0010;
        tick(3);
        chk_reg("t3_pend", A_PENDING, 16'h0002);
        chk_reg("t3_no_ovf", A_STATUS, 16'h0000);
        src_in = 4'b0000;
        tick(3);
        src_in = 4'b0010;
        tick(3);
        chk_reg("t3_ovf", A_STATUS, 16'h0200);
        wreg(A_STATUS, 16'h0200, 2'b01);
        chk_reg("t3_ovf_lowlane", A_STATUS, 16'h0200);
        wreg(A_STATUS, 16'h0200, 2'b10);
        chk_reg("t3_ovf_clr", A_STATUS, 16'h0000);
        chk_reg("t3_pend_kept", A_PENDING, 16'h0002);
        src_in = 4'b0000;
        wreg(A_PENDING, 16'h0002, 2'b01);
        chk_reg("t3_pend_clr", A_PENDING, 16'h0000);

        // W1C colliding with a new edge: set wins, no overflow
        wreg(A_CTRL, 16'h0001, 2'b11);
        src_in = 4'b0001;
        tick(3);
        chk_reg("t4_pend_first", A_PENDING, 16'h0001);
        src_in = 4'b0000;
        tick(3);
        src_in = 4'b0001;
        tick(2);
        wreg(A_PENDING, 16'h0001, 2'b01);
        chk_reg("t4_set_wins", A_PENDING, 16'h0001);
        chk_reg("t4_no_ovf", A_STATUS, 16'h0000);
        wreg(A_PENDING, 16'h0001, 2'b01);
        chk_reg("t4_pend_clr", A_PENDING, 16'h0000);
        src_in = 4'b0000;
        tick(3);

        // Polarity change never fires; spurious IACK from IDLE
        wreg(A_CTRL, 16'h0009, 2'b01);
        tick(4);
        chk_reg("t5_inv_no_edge", A_PENDING, 16'h0000);
        wreg(A_CTRL, 16'h0000, 2'b11);
        wreg(A_MASK, 16'h0007, 2'b01);
        chk_reg("t5_mask", A_MASK, 16'h0007);
        cpu_fc = 3'b111; iack_level = 3'd2; cpu_as_n = 1'b0;
        tick(1);
        chk("t5_vpa", 16'(vpa_n), 16'h0000);
        chk("t5_ipl", 16'(ipl_n), 16'h0007);
        chk_reg("t5_spurious", A_STATUS, 16'h0004);
        chk_reg("t5_pend", A_PENDING, 16'h0000);

        // Asynchronous reset while in ACK
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_vpa", 16'(vpa_n), 16'h0001);
        chk("t6_ipl", 16'(ipl_n), 16'h0007);
        chk_reg("t6_mask", A_MASK, 16'h0000);
        chk_reg("t6_status", A_STATUS, 16'h0000);
        cpu_as_n = 1'b1;
        cpu_fc   = 3'b000;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        chk("t6_vpa_after", 16'(vpa_n), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
